// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith ops, WIDTH-step shift-add MUL and
// restoring DIV. Result and flags are registered and held until out_ready.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [WIDTH-1:0] ALU_Hi,
    output logic             CarryOut,
    output logic             ZeroFlag,
    output logic             OverflowFlag,
    output logic             NegativeFlag,
    output logic             DivByZero
);
    localparam int CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {stIdle, stMul, stDiv, stDone} state_t;

    state_t            state;
    logic [CntW-1:0]   iterCnt;
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  accHi;
    logic [WIDTH-1:0]  accLo;

    logic [WIDTH-1:0]  sRes;
    logic              sCarry;
    logic              sOvf;
    logic [WIDTH:0]    mulSum;
    logic [WIDTH:0]    divShift;
    logic              divGe;
    logic [WIDTH-1:0]  divDiff;
    logic [WIDTH-1:0]  nxtHi;
    logic [WIDTH-1:0]  nxtLo;

    assign in_ready  = (state == stIdle);
    assign out_valid = (state == stDone);

    always_comb begin
        sRes   = '0;
        sCarry = 1'b0;
        sOvf   = 1'b0;
        case (ALU_Sel)
            4'b0000: begin
                {sCarry, sRes} = {1'b0, A} + {1'b0, B};
                sOvf = (A[WIDTH-1] == B[WIDTH-1]) && (sRes[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0001: begin
                sRes   = A - B;
                sCarry = (A < B);
                sOvf   = (A[WIDTH-1] != B[WIDTH-1]) && (sRes[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0010: sRes = A & B;
            4'b0011: sRes = A | B;
            4'b0100: sRes = A ^ B;
            4'b0101: sRes = ~A;
            4'b0110: begin
                sRes   = {A[WIDTH-2:0], 1'b0};
                sCarry = A[WIDTH-1];
            end
            4'b0111: begin
                sRes   = {1'b0, A[WIDTH-1:1]};
                sCarry = A[0];
            end
            4'b1010: sRes = {{(WIDTH-1){1'b0}}, (A == B)};
            4'b1011: sRes = {{(WIDTH-1){1'b0}}, (A > B)};
            4'b1100: sRes = {{(WIDTH-1){1'b0}}, (A < B)};
            default: sRes = '0;
        endcase
    end

    // MUL: accHi:accLo is the product register, multiplier in accLo shifts out LSB-first.
    // DIV: accHi is the partial remainder, accLo the dividend shifting into the quotient.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divGe    = (divShift >= {1'b0, opnd});
        divDiff  = divShift[WIDTH-1:0] - opnd;
        if (state == stDiv) begin
            nxtHi = divGe ? divDiff : divShift[WIDTH-1:0];
            nxtLo = {accLo[WIDTH-2:0], divGe};
        end else begin
            nxtHi = mulSum[WIDTH:1];
            nxtLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= stIdle;
            iterCnt      <= '0;
            opnd         <= '0;
            accHi        <= '0;
            accLo        <= '0;
            ALU_Out      <= '0;
            ALU_Hi       <= '0;
            CarryOut     <= 1'b0;
            ZeroFlag     <= 1'b0;
            OverflowFlag <= 1'b0;
            NegativeFlag <= 1'b0;
            DivByZero    <= 1'b0;
        end else begin
            case (state)
                stIdle: begin
                    if (in_valid) begin
                        iterCnt <= '0;
                        accHi   <= '0;
                        if (ALU_Sel == 4'b1000) begin
                            opnd  <= A;
                            accLo <= B;
                            state <= stMul;
                        end else if (ALU_Sel == 4'b1001 && B != '0) begin
                            opnd  <= B;
                            accLo <= A;
                            state <= stDiv;
                        end else begin
                            ALU_Out      <= sRes;
                            ALU_Hi       <= '0;
                            CarryOut     <= sCarry;
                            ZeroFlag     <= (sRes == '0);
                            OverflowFlag <= sOvf;
                            NegativeFlag <= sRes[WIDTH-1];
                            DivByZero    <= (ALU_Sel == 4'b1001);
                            state        <= stDone;
                        end
                    end
                end
                stMul, stDiv: begin
                    accHi <= nxtHi;
                    accLo <= nxtLo;
                    if (iterCnt == CntW'(WIDTH - 1)) begin
                        ALU_Out      <= nxtLo;
                        ALU_Hi       <= nxtHi;
                        CarryOut     <= (state == stMul) && (nxtHi != '0);
                        ZeroFlag     <= (nxtLo == '0);
                        OverflowFlag <= 1'b0;
                        NegativeFlag <= nxtLo[WIDTH-1];
                        DivByZero    <= 1'b0;
                        state        <= stDone;
                    end else begin
                        iterCnt <= iterCnt + CntW'(1);
                    end
                end
                stDone: begin
                    if (out_ready) state <= stIdle;
                end
                default: state <= stIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks for alu_mc (WIDTH=8): results, flags, latency,
// backpressure hold, reset abort and handshake accounting.
module tb_alu_mc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [3:0] ALU_Sel = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] ALU_Out;
    logic [7:0] ALU_Hi;
    logic       CarryOut, ZeroFlag, OverflowFlag, NegativeFlag, DivByZero;

    int total = 0;
    int bad = 0;
    int doneCnt = 0;
    int expDone = 0;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Out(ALU_Out), .ALU_Hi(ALU_Hi), .CarryOut(CarryOut), .ZeroFlag(ZeroFlag),
        .OverflowFlag(OverflowFlag), .NegativeFlag(NegativeFlag), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) doneCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {CarryOut, ZeroFlag, OverflowFlag, NegativeFlag, DivByZero};
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        ALU_Sel  = op;
        A        = a;
        B        = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A        = ~a;
        B        = a ^ b;
        ALU_Sel  = ~op;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkRes(input string tag, input int lat, input int expLat,
                            input logic [7:0] eo, input logic [7:0] eh, input logic [4:0] ef);
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_out"}, ALU_Out, eo);
        check({tag, "_hi"}, ALU_Hi, eh);
        check({tag, "_flags"}, flags(), ef);
        expDone++;
    endtask

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] eo, output logic [7:0] eh, output logic [4:0] ef);
        logic [8:0]  s;
        logic [15:0] p;
        logic c, o, dz;
        eo = 8'h00; eh = 8'h00; c = 1'b0; o = 1'b0; dz = 1'b0;
        case (op)
            4'd0: begin s = a + b; eo = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (eo[7] != a[7]); end
            4'd1: begin eo = a - b; c = (a < b); o = (a[7] != b[7]) && (eo[7] != a[7]); end
            4'd2: eo = a & b;
            4'd3: eo = a | b;
            4'd4: eo = a ^ b;
            4'd5: eo = ~a;
            4'd6: begin eo = a << 1; c = a[7]; end
            4'd7: begin eo = a >> 1; c = a[0]; end
            4'd8: begin p = a * b; eo = p[7:0]; eh = p[15:8]; c = (eh != 0); end
            4'd9: begin
                if (b == 0) dz = 1'b1;
                else begin eo = a / b; eh = a % b; end
            end
            4'd10: eo = (a == b) ? 8'd1 : 8'd0;
            4'd11: eo = (a > b) ? 8'd1 : 8'd0;
            4'd12: eo = (a < b) ? 8'd1 : 8'd0;
            default: eo = 8'h00;
        endcase
        ef = {c, (eo == 0), o, eo[7], dz};
    endtask

    initial begin
        int lat;
        int sawValid;
        logic [3:0] op;
        logic [7:0] a, b, eo, eh;
        logic [4:0] ef;
        int stall;

        #2 rst_n = 1'b0;
        #10;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out", {ALU_Hi, ALU_Out}, 16'h0000);
        check("rst_flags", flags(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0000, 8'hFF, 8'h01, lat); checkRes("add_ff_01", lat, 1, 8'h00, 8'h00, 5'b11000);
        issue(4'b0000, 8'h7F, 8'h01, lat); checkRes("add_7f_01", lat, 1, 8'h80, 8'h00, 5'b00110);
        issue(4'b1000, 8'h10, 8'h10, lat); checkRes("mul_10_10", lat, 9, 8'h00, 8'h01, 5'b11000);
        issue(4'b1000, 8'hFF, 8'hFF, lat); checkRes("mul_ff_ff", lat, 9, 8'h01, 8'hFE, 5'b10000);
        issue(4'b1001, 8'd200, 8'd7, lat); checkRes("div_200_7", lat, 9, 8'h1C, 8'h04, 5'b00000);
        issue(4'b1001, 8'd5, 8'd0, lat);   checkRes("div_5_0", lat, 1, 8'h00, 8'h00, 5'b01001);
        issue(4'b0110, 8'h81, 8'h00, lat); checkRes("shl_81", lat, 1, 8'h02, 8'h00, 5'b10000);
        issue(4'b0111, 8'h81, 8'h00, lat); checkRes("shr_81", lat, 1, 8'h40, 8'h00, 5'b10000);
        issue(4'b1011, 8'h05, 8'h03, lat); checkRes("gt_5_3", lat, 1, 8'h01, 8'h00, 5'b00000);
        issue(4'b1110, 8'h55, 8'hAA, lat); checkRes("op_1110", lat, 1, 8'h00, 8'h00, 5'b01000);

        @(negedge clk);
        out_ready = 1'b0;
        issue(4'b0001, 8'h03, 8'h05, lat); checkRes("sub_03_05", lat, 1, 8'hFE, 8'h00, 5'b10010);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            A = 8'($urandom);
            B = 8'($urandom);
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_hold", {ALU_Hi, ALU_Out, 3'b000, flags()}, {16'h00FE, 8'b000_10010});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Abort a divide partway through its iterations.
        in_valid = 1'b1; ALU_Sel = 4'b1001; A = 8'd200; B = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out", {ALU_Hi, ALU_Out}, 16'h0000);
        check("abort_flags", flags(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        check("abort_no_valid", sawValid, 0);
        issue(4'b0010, 8'hF0, 8'h3C, lat); checkRes("and_f0_3c", lat, 1, 8'h30, 8'h00, 5'b00000);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, a, b, lat);
            model(op, a, b, eo, eh, ef);
            checkRes($sformatf("rnd%0d_op%0h", i, op), lat,
                     (op == 4'd8 || (op == 4'd9 && b != 0)) ? 9 : 1, eo, eh, ef);
            if (stall > 0) begin
                repeat (stall) @(negedge clk);
                check($sformatf("rnd%0d_hold", i), {ALU_Hi, ALU_Out, 3'b000, flags()},
                      {eh, eo, 3'b000, ef});
                out_ready = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        check("handshake_count", doneCnt, expDone);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
